// File: rtl/alu_decode_stage.sv
// RV32I integer-ALU decode stage: turns an instruction word into the alu_32 control word
// behind a single-entry valid/ready output register with flush.
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_uop,
    output logic        out_f7,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic        out_op2_imm,
    output logic        out_op1_pc,
    output logic        out_rd_we,
    output logic        out_illegal,
    output logic [31:0] out_pc
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [2:0]  uop;
        logic        f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        op2_imm;
        logic        op1_pc;
        logic        rd_we;
        logic        illegal;
    } ctrl_t;

    // Any encoding that fails its legality test collapses to an all-zero word with only illegal set.
    function automatic ctrl_t decode_instr(input logic [31:0] instr);
        ctrl_t              d;
        logic               legal;
        logic        [6:0]  opcode;
        logic        [2:0]  funct3;
        logic        [6:0]  funct7;
        logic signed [11:0] imm_i;
        logic signed [31:0] imm_sext;
        d        = '0;
        legal    = 1'b0;
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        funct7   = instr[31:25];
        imm_i    = signed'(instr[31:20]);
        imm_sext = 32'(imm_i);
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                d.uop = funct3;
                d.f7  = instr[30];
                d.rs1 = instr[19:15];
                d.rs2 = instr[24:20];
                d.rd  = instr[11:7];
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b001:  legal = (funct7 == F7_ZERO);
                    3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
                d.uop     = funct3;
                d.f7      = (funct3 == 3'b101) ? instr[30] : 1'b0;
                d.rs1     = instr[19:15];
                d.rd      = instr[11:7];
                d.op2_imm = 1'b1;
                if ((funct3 == 3'b001) || (funct3 == 3'b101))
                    d.imm = {27'b0, instr[24:20]};
                else
                    d.imm = imm_sext;
            end
            OPC_LUI, OPC_AUIPC: begin
                legal     = 1'b1;
                d.rd      = instr[11:7];
                d.op2_imm = 1'b1;
                d.op1_pc  = (opcode == OPC_AUIPC);
                d.imm     = {instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            d.rd_we = (d.rd != 5'd0);
        end else begin
            d         = '0;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    ctrl_t       ctrl_p0;
    logic [31:0] pc_p0;
    logic        vld_p0;
    logic        accept;
    ctrl_t       dec;

    assign in_ready = rst_n & ~flush & (~vld_p0 | out_ready);
    assign accept   = in_valid & in_ready;
    assign dec      = decode_instr(in_instr);

    // ---- stage p0: output register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            ctrl_p0 <= '0;
            pc_p0   <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            ctrl_p0 <= dec;
            pc_p0   <= in_pc;
        end else if (out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_valid   = vld_p0;
    assign out_uop     = ctrl_p0.uop;
    assign out_f7      = ctrl_p0.f7;
    assign out_rs1     = ctrl_p0.rs1;
    assign out_rs2     = ctrl_p0.rs2;
    assign out_rd      = ctrl_p0.rd;
    assign out_imm     = ctrl_p0.imm;
    assign out_op2_imm = ctrl_p0.op2_imm;
    assign out_op1_pc  = ctrl_p0.op1_pc;
    assign out_rd_we   = ctrl_p0.rd_we;
    assign out_illegal = ctrl_p0.illegal;
    assign out_pc      = pc_p0;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage using immediate assertions.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_uop;
    logic        out_f7;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_op2_imm;
    logic        out_op1_pc;
    logic        out_rd_we;
    logic        out_illegal;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
        .out_f7(out_f7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_op2_imm(out_op2_imm), .out_op1_pc(out_op1_pc),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full control-word check of the currently presented entry.
    task automatic check_word(input string tag, input logic [2:0] uop, input logic f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic op2_imm, input logic op1_pc,
                              input logic rd_we, input logic illegal, input logic [31:0] pc);
        check({tag, ".valid"},   32'(out_valid),   32'd1);
        check({tag, ".uop"},     32'(out_uop),     32'(uop));
        check({tag, ".f7"},      32'(out_f7),      32'(f7));
        check({tag, ".rs1"},     32'(out_rs1),     32'(rs1));
        check({tag, ".rs2"},     32'(out_rs2),     32'(rs2));
        check({tag, ".rd"},      32'(out_rd),      32'(rd));
        check({tag, ".imm"},     out_imm,          imm);
        check({tag, ".op2_imm"}, 32'(out_op2_imm), 32'(op2_imm));
        check({tag, ".op1_pc"},  32'(out_op1_pc),  32'(op1_pc));
        check({tag, ".rd_we"},   32'(out_rd_we),   32'(rd_we));
        check({tag, ".illegal"}, 32'(out_illegal), 32'(illegal));
        check({tag, ".pc"},      out_pc,           pc);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b1;
        step();
        step();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.imm", out_imm, 32'd0);
        check("rst.pc", out_pc, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle.in_ready", 32'(in_ready), 32'd1);

        // back-to-back stream with out_ready held high
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
        step();
        in_instr = 32'h402081B3; in_pc = 32'h104;
        check_word("add", 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        step();
        in_instr = 32'hFFF00093; in_pc = 32'h108;
        check_word("sub", 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h104);
        step();
        in_instr = 32'h40335293; in_pc = 32'h10C;
        check_word("addi", 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h108);
        step();
        in_instr = 32'h123453B7; in_pc = 32'h110;
        check_word("srai", 3'b101, 1'b1, 5'd6, 5'd0, 5'd5, 32'h3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10C);
        step();
        in_instr = 32'h00001117; in_pc = 32'h114;
        check_word("lui", 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'h12345000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h110);
        step();
        in_instr = 32'h022081B3; in_pc = 32'h118;
        check_word("auipc", 3'b000, 1'b0, 5'd0, 5'd0, 5'd2, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h114);
        step();
        in_instr = 32'h00002083; in_pc = 32'h11C;
        check_word("mul", 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h118);
        step();
        in_instr = 32'h402091B3; in_pc = 32'h120;
        check_word("load", 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11C);
        step();
        in_instr = 32'h00208033; in_pc = 32'h124;
        check_word("sll_f7alt", 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h120);
        step();
        in_valid = 1'b0;
        check_word("add_rd0", 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h124);
        step();
        check("drain.valid", 32'(out_valid), 32'd0);

        // backpressure: ADD held while SUB waits at the input
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200;
        step();
        in_instr = 32'h402081B3; in_pc = 32'h204; out_ready = 1'b0;
        #1;
        check("bp.in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.valid", 32'(out_valid), 32'd1);
            check("bp.pc", out_pc, 32'h200);
            check("bp.f7", 32'(out_f7), 32'd0);
            check("bp.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_word("bp.sub", 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h204);
        step();
        check("bp.no_dup", 32'(out_valid), 32'd0);

        // flush of a stalled entry blocks the concurrent input
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300;
        step();
        out_ready = 1'b0; in_instr = 32'h402081B3; in_pc = 32'h304;
        step();
        check("fl.stalled_pc", out_pc, 32'h300);
        flush = 1'b1;
        #1;
        check("fl.in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl.valid", 32'(out_valid), 32'd0);
        step();
        check("fl.not_accepted", 32'(out_valid), 32'd0);

        // reset mid-stall, then a fresh accept
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h400;
        step();
        check("rs.pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs.in_ready", 32'(in_ready), 32'd0);
        step();
        check("rs.valid", 32'(out_valid), 32'd0);
        check("rs.pc", out_pc, 32'd0);
        check("rs.rd", 32'(out_rd), 32'd0);
        check("rs.rd_we", 32'(out_rd_we), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1; in_instr = 32'h123453B7; in_pc = 32'h500;
        step();
        in_valid = 1'b0;
        check_word("rs.lui", 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'h12345000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that turns a 32-bit RV32I integer-ALU instruction into the control word consumed by `alu_32`: `uop`, `f7`, operand selects, immediate and register indices. It sits between fetch and execute, accepts one instruction per cycle over a valid/ready handshake, and holds a single-entry output register that stalls under backpressure and clears on flush. Unsupported encodings are passed through flagged illegal, with no register write.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction address.
- `flush`  in  1  discard held entry; block input this cycle.
- `out_valid`  out  1  control word present.
- `out_ready`  in  1  execute consumes.
- `out_uop`  out  3  ALU op, same encoding as `alu_32`.
- `out_f7`  out  1  sub / arithmetic-shift select.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices.
- `out_imm`  out  32  decoded immediate.
- `out_op2_imm`  out  1  op2 = `out_imm`, not rs2.
- `out_op1_pc`  out  1  op1 = `out_pc`, not rs1.
- `out_rd_we`  out  1  write rd.
- `out_illegal`  out  1  unsupported encoding.
- `out_pc`  out  32  registered `in_pc`.

## Operation
- Supported opcodes:
  - OP `0110011`
  - OP-IMM `0010011`
  - LUI `0110111`
  - AUIPC `0010111`
  - Everything else is illegal.
- OP decode:
  - `uop` = funct3; `f7` = instr[30]; `op2_imm` = 0; `imm` = 0.
  - Legal funct7 is `0000000` for any funct3.
  - `0100000` is legal only with funct3 000 (SUB) or 101 (SRA).
  - All other funct7 values (including M-ext `0000001`) are illegal.
- OP-IMM decode:
  - `uop` = funct3; `op2_imm` = 1; `imm` = sign-extended instr[31:20].
  - `f7` is forced 0, except funct3 101, where `f7` = instr[30].
  - funct3 001 requires instr[31:25] = `0000000`.
  - funct3 101 requires instr[31:25] ∈ {`0000000`, `0100000`}.
  - For both shifts, `imm` = {27'b0, instr[24:20]}; otherwise the encoding is illegal.
- LUI: `uop` = 000, `f7` = 0, `rs1` forced 0, `op2_imm` = 1, `imm` = {instr[31:12], 12'b0}.
- AUIPC: same as LUI, but `rs1` = instr[19:15] is don't-care and `op1_pc` = 1.
- Register fields:
  - `rd` = instr[11:7], `rs1` = instr[19:15], `rs2` = instr[24:20].
  - `rs2` is forced 0 when `op2_imm` = 1.
- `rd_we` = legal AND rd ≠ 0.
- Illegal entries:
  - `out_illegal` = 1, `rd_we` = 0.
  - `uop`, `f7`, `imm`, `op2_imm`, `op1_pc` all 0; `rs1`/`rs2`/`rd` 0.
  - The entry still presents `out_valid` for exception handling.
- Output register is a single entry; decode is combinational into it.

## Timing
- Reset (`rst_n` = 0 at a clock edge):
  - All outputs are 0 next cycle, including `out_valid`.
  - `in_ready` = 0 while `rst_n` = 0.
- `in_ready` = `rst_n` & ~`flush` & (~`out_valid` | `out_ready`), combinational.
- Accept: `in_valid` & `in_ready` at the edge.
  - Decoded word and `out_valid` = 1 appear the next cycle (latency 1).
  - Full throughput is one instruction per cycle with `out_ready` held 1.
- Consume: `out_valid` & `out_ready` at the edge.
  - `out_valid` falls next cycle unless a new accept occurs in the same cycle (simultaneous consume+accept replaces the entry, `out_valid` stays 1).
- Stall: while `out_valid` & ~`out_ready`, all `out_*` hold bit-stable and `in_ready` = 0.
- Flush: `flush` = 1 at an edge clears `out_valid` next cycle regardless of `out_ready`, and no input is accepted that cycle.
  - Data fields may keep stale values.
  - Reset has priority over flush.
- Reset mid-stall drops the held entry; the first accept after reset behaves as from empty.

## Test plan
- ADD / SUB:
  - `0x002081B3` → uop 000, f7 0, rs1 1, rs2 2, rd 3, op2_imm 0, rd_we 1.
  - `0x402081B3` → same with f7 1.
  - Both back-to-back with `out_ready` = 1 → two consecutive `out_valid` cycles.
- ADDI sign / f7 masking: `0xFFF00093` → uop 000, f7 0 (instr[30] = 1 ignored), imm `0xFFFFFFFF`, op2_imm 1, rs2 0, rd 1.
- SRAI and LUI:
  - `0x40335293` → uop 101, f7 1, imm 3, rs1 6, rd 5.
  - `0x123453B7` → uop 000, imm `0x12345000`, rs1 0, rd 7, op1_pc 0.
- Illegal:
  - `0x022081B3` (MUL) → out_illegal 1, rd_we 0, uop 0, out_valid 1.
  - Opcode `0000011` (load) → also illegal.
  - `0x402091B3` (funct7 `0100000` with funct3 001) → illegal.
- Backpressure: accept ADD, hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 with SUB.
  - `in_ready` stays 0 and outputs stay the ADD word.
  - Raising `out_ready` gives SUB on the next cycle with no bubble, and no instruction is lost or duplicated.
- Flush / reset: with a stalled entry, pulse `flush` together with `in_valid` = 1.
  - `out_valid` = 0 next cycle; the input is not accepted (`in_ready` = 0).
  - Assert `rst_n` = 0 mid-stream → all outputs 0 next cycle; after release, the first instruction appears 1 cycle after accept.
